// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared screen geometry, bird physics constants and life-cycle state encoding
package flappy_pkg;

    localparam int BIRD_X_POS   = 300;
    localparam int START_Y      = 344;
    localparam int BIRD_H       = 30;
    localparam int GRAVITY      = 1;
    localparam int JUMP_VEL     = 8;
    localparam int MAX_FALL_VEL = 10;
    localparam int GROUND_Y     = 668;
    localparam int CEILING_Y    = 20;
    localparam int PIPE_WIDTH   = 60;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_FALL = 2'd2,
        ST_DEAD = 2'd3
    } bird_state_t;

endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - two-flop synchroniser for an asynchronous key, followed by a rising-edge pulse
module key_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/bird_physics.sv
// rtl/bird_physics.sv - bird vertical motion, jump handling and IDLE/FLY/FALL/DEAD life cycle
module bird_physics
    import flappy_pkg::*;
#(
    parameter int BIRD_X_POS_P   = BIRD_X_POS,
    parameter int START_Y_P      = START_Y,
    parameter int BIRD_H_P       = BIRD_H,
    parameter int GRAVITY_P      = GRAVITY,
    parameter int JUMP_VEL_P     = JUMP_VEL,
    parameter int MAX_FALL_VEL_P = MAX_FALL_VEL,
    parameter int GROUND_Y_P     = GROUND_Y,
    parameter int CEILING_Y_P    = CEILING_Y
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_en,
    input  logic        key_jump,
    input  logic        ai_jump_pulse,
    input  logic        auto_mode,
    input  logic        start_pulse,
    input  logic        collide,
    output logic [11:0] bird_x,
    output logic [11:0] bird_y,
    output logic [7:0]  bird_vel,
    output logic        game_active,
    output logic        bird_dead,
    output logic        hit_ground
);

    localparam logic signed [12:0] GRAV_S   = 13'(GRAVITY_P);
    localparam logic signed [12:0] JUMP_S   = 13'(JUMP_VEL_P);
    localparam logic signed [12:0] MAXF_S   = 13'(MAX_FALL_VEL_P);
    localparam logic signed [12:0] CEIL_S   = 13'(CEILING_Y_P);
    localparam logic signed [12:0] GROUND_S = 13'(GROUND_Y_P);
    localparam logic signed [12:0] H_S      = 13'(BIRD_H_P);
    localparam logic [11:0]        START_U  = 12'(START_Y_P);
    localparam logic [11:0]        CEIL_U   = 12'(CEILING_Y_P);
    localparam logic [11:0]        LAND_U   = 12'(GROUND_Y_P - BIRD_H_P);

    logic key_edge;
    logic jump_req;

    key_edge_sync u_key_sync (
        .clk   (clk),
        .rst   (rst),
        .key   (key_jump),
        .pulse (key_edge)
    );

    // Whoever does not hold control has its jump source masked off.
    assign jump_req = auto_mode ? ai_jump_pulse : key_edge;
    assign bird_x   = 12'(BIRD_X_POS_P);

    bird_state_t state, state_d;
    logic        jump_pend, pend_d, hit_d, do_phys;
    logic [11:0] y_d;
    logic [7:0]  vel_d;

    logic signed [12:0] vel_cur, vel_grav, vel_n, y_n;
    logic               phys_jump, ceiling_hit, ground_hit;

    always_comb begin
        phys_jump   = (state == ST_FLY) & (jump_pend | jump_req);
        vel_cur     = $signed({{5{bird_vel[7]}}, bird_vel});
        vel_grav    = vel_cur + GRAV_S;
        if (vel_grav > MAXF_S)
            vel_grav = MAXF_S;
        vel_n       = phys_jump ? -JUMP_S : vel_grav;
        y_n         = $signed({1'b0, bird_y}) + vel_n;
        ceiling_hit = y_n < CEIL_S;
        ground_hit  = (y_n + H_S) >= GROUND_S;
    end

    always_comb begin
        state_d = state;
        y_d     = bird_y;
        vel_d   = bird_vel;
        pend_d  = jump_pend | jump_req;
        hit_d   = 1'b0;
        do_phys = 1'b0;
        case (state)
            ST_IDLE: begin
                y_d    = START_U;
                vel_d  = 8'd0;
                pend_d = start_pulse | jump_req;
                if (start_pulse | jump_req)
                    state_d = ST_FLY;
            end
            ST_FLY: begin
                // A collision pre-empts the frame step and drops any pending jump.
                if (collide) begin
                    state_d = ST_FALL;
                    vel_d   = 8'd0;
                    pend_d  = 1'b0;
                end else if (frame_en) begin
                    do_phys = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            ST_FALL: begin
                pend_d  = 1'b0;
                do_phys = frame_en;
            end
            ST_DEAD: begin
                pend_d = 1'b0;
                if (start_pulse) begin
                    state_d = ST_IDLE;
                    y_d     = START_U;
                    vel_d   = 8'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_phys) begin
            if (ceiling_hit) begin
                y_d   = CEIL_U;
                vel_d = 8'd0;
            end else if (ground_hit) begin
                y_d     = LAND_U;
                vel_d   = 8'd0;
                hit_d   = 1'b1;
                state_d = ST_DEAD;
                pend_d  = 1'b0;
            end else begin
                y_d   = 12'(y_n);
                vel_d = 8'(vel_n);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bird_y      <= START_U;
            bird_vel    <= 8'd0;
            jump_pend   <= 1'b0;
            hit_ground  <= 1'b0;
            game_active <= 1'b0;
            bird_dead   <= 1'b0;
        end else begin
            bird_y      <= y_d;
            bird_vel    <= vel_d;
            jump_pend   <= pend_d;
            hit_ground  <= hit_d;
            game_active <= (state_d == ST_FLY);
            bird_dead   <= (state_d == ST_DEAD);
        end
    end

endmodule

// File: tb/tb_bird_physics.sv
// tb/tb_bird_physics.sv - directed stimulus with a behavioural bird model and literal pin-point checks
module tb_bird_physics;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_en = 1'b0;
    logic        key_jump = 1'b0;
    logic        ai_jump_pulse = 1'b0;
    logic        auto_mode = 1'b0;
    logic        start_pulse = 1'b0;
    logic        collide = 1'b0;
    logic [11:0] bird_x;
    logic [11:0] bird_y;
    logic [7:0]  bird_vel;
    logic        game_active;
    logic        bird_dead;
    logic        hit_ground;

    int checks = 0;
    int errors = 0;

    bird_physics dut (
        .clk           (clk),
        .rst           (rst),
        .frame_en      (frame_en),
        .key_jump      (key_jump),
        .ai_jump_pulse (ai_jump_pulse),
        .auto_mode     (auto_mode),
        .start_pulse   (start_pulse),
        .collide       (collide),
        .bird_x        (bird_x),
        .bird_y        (bird_y),
        .bird_vel      (bird_vel),
        .game_active   (game_active),
        .bird_dead     (bird_dead),
        .hit_ground    (hit_ground)
    );

    always #5 clk = ~clk;

    // Behavioural model: life stage as a name, position and speed as plain integers.
    string m_stage = "idle";
    int    m_y     = 344;
    int    m_vel   = 0;
    bit    m_pend  = 0;
    bit    m_hit   = 0;
    bit    key_hist [3];

    task automatic model_frame(input bit jump);
        int v;
        int y;
        if (jump) v = -8;
        else      v = (m_vel + 1 > 10) ? 10 : m_vel + 1;
        y = m_y + v;
        if (y < 20) begin
            m_y = 20; m_vel = 0;
        end else if (y + 30 >= 668) begin
            m_y = 638; m_vel = 0; m_hit = 1; m_stage = "dead"; m_pend = 0;
        end else begin
            m_y = y; m_vel = v;
        end
    endtask

    always begin
        bit key_rise;
        bit req;
        @(posedge clk);
        if (rst) begin
            m_stage = "idle"; m_y = 344; m_vel = 0; m_pend = 0; m_hit = 0;
            key_hist[0] = 0; key_hist[1] = 0; key_hist[2] = 0;
        end else begin
            key_rise = key_hist[1] && !key_hist[2];
            key_hist[2] = key_hist[1];
            key_hist[1] = key_hist[0];
            key_hist[0] = key_jump;
            req = auto_mode ? ai_jump_pulse : key_rise;
            m_hit = 0;
            if (m_stage == "idle") begin
                if (start_pulse || req) begin
                    m_stage = "fly"; m_pend = 1;
                end
            end else if (m_stage == "fly") begin
                if (collide) begin
                    m_stage = "fall"; m_vel = 0; m_pend = 0;
                end else if (frame_en) begin
                    bit j;
                    j = m_pend || req;
                    m_pend = 0;
                    model_frame(j);
                end else if (req) begin
                    m_pend = 1;
                end
            end else if (m_stage == "fall") begin
                if (frame_en) model_frame(0);
            end else if (m_stage == "dead") begin
                if (start_pulse) begin
                    m_stage = "idle"; m_y = 344; m_vel = 0;
                end
            end
        end
        #2;
        checks++;
        if (bird_y !== 12'(m_y) || int'($signed(bird_vel)) != m_vel ||
            game_active !== (m_stage == "fly") || bird_dead !== (m_stage == "dead") ||
            hit_ground !== m_hit || bird_x !== 12'd300) begin
            errors++;
            $display("FAIL model t=%0t: y=%0d vel=%0d act=%b dead=%b hit=%b x=%0d, need y=%0d vel=%0d stage=%s hit=%b x=300",
                     $time, bird_y, $signed(bird_vel), game_active, bird_dead, hit_ground, bird_x,
                     m_y, m_vel, m_stage, m_hit);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic frame(input logic ai, input logic col);
        @(negedge clk);
        frame_en = 1'b1; ai_jump_pulse = ai; collide = col;
        @(negedge clk);
        frame_en = 1'b0; ai_jump_pulse = 1'b0; collide = 1'b0;
    endtask

    task automatic start;
        @(negedge clk);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
    endtask

    task automatic press_key;
        @(negedge clk);
        key_jump = 1'b1;
        repeat (4) @(negedge clk);
        key_jump = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic int vel_now();
        return int'($signed(bird_vel));
    endfunction

    initial begin
        int hits;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_y", bird_y, 344);
        chk("reset_vel", vel_now(), 0);
        chk("reset_active", game_active, 0);
        chk("reset_dead", bird_dead, 0);
        chk("reset_hit", hit_ground, 0);
        chk("bird_x", bird_x, 300);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start;
        frame(0, 0);
        chk("f1_vel", vel_now(), -8);  chk("f1_y", bird_y, 336);
        frame(0, 0);
        chk("f2_vel", vel_now(), -7);  chk("f2_y", bird_y, 329);
        frame(0, 0);
        chk("f3_vel", vel_now(), -6);  chk("f3_y", bird_y, 323);
        chk("f3_active", game_active, 1);

        auto_mode = 1'b1;
        press_key;
        frame(0, 0);
        chk("masked_key_vel", vel_now(), -5); chk("masked_key_y", bird_y, 318);
        auto_mode = 1'b0;
        press_key;
        frame(0, 0);
        chk("key_jump_vel", vel_now(), -8); chk("key_jump_y", bird_y, 310);

        auto_mode = 1'b1;
        frame(1, 1);
        chk("collide_vel", vel_now(), 0);  chk("collide_y", bird_y, 310);
        chk("collide_active", game_active, 0);
        frame(1, 0);
        chk("fall1_vel", vel_now(), 1);  chk("fall1_y", bird_y, 311);
        frame(0, 0);
        chk("fall2_vel", vel_now(), 2);  chk("fall2_y", bird_y, 313);
        frame(0, 0);
        chk("fall3_vel", vel_now(), 3);  chk("fall3_y", bird_y, 316);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_y", bird_y, 344);
        chk("async_rst_vel", vel_now(), 0);
        chk("async_rst_dead", bird_dead, 0);
        chk("async_rst_active", game_active, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        auto_mode = 1'b0;
        repeat (2) @(negedge clk);

        start;
        frame(0, 0);
        chk("restart_y", bird_y, 336);
        press_key;
        press_key;
        frame(0, 0);
        chk("double_key_vel", vel_now(), -8); chk("double_key_y", bird_y, 328);

        auto_mode = 1'b1;
        repeat (38) frame(1, 0);
        chk("near_ceiling_y", bird_y, 24); chk("near_ceiling_vel", vel_now(), -8);
        frame(1, 0);
        chk("ceiling_y", bird_y, 20); chk("ceiling_vel", vel_now(), 0);
        chk("ceiling_active", game_active, 1);

        hits = 0;
        for (int i = 0; i < 200 && !bird_dead; i++) begin
            frame(0, 0);
            if (hit_ground) hits++;
        end
        chk("ground_dead", bird_dead, 1);
        chk("ground_y", bird_y, 638);
        chk("ground_hits", hits, 1);
        chk("ground_active", game_active, 0);
        @(negedge clk);
        chk("ground_hit_cleared", hit_ground, 0);

        start;
        chk("idle_y", bird_y, 344); chk("idle_vel", vel_now(), 0);
        chk("idle_dead", bird_dead, 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
